// File: rtl/prim_arb_req_stage.sv
// prim_arb_req_stage: per-port FIFOs feeding a round-robin arbiter, with occupancy, starvation watchdog and grant error flags
module prim_arb_req_stage #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int Depth   = 2,
    parameter int MaxWait = 16,
    parameter int CntW    = $clog2(Depth + 1),
    parameter int WaitW   = $clog2(MaxWait + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N-1:0]             valid_i,
    output logic [N-1:0]             ready_o,
    input  logic [DW-1:0]            data_i [N],
    output logic [N-1:0]             req_o,
    output logic [DW-1:0]            data_o [N],
    input  logic [N-1:0]             gnt_i,
    output logic [N-1:0][CntW-1:0]   cnt_o,
    output logic [N-1:0]             stall_o,
    input  logic                     stall_clr_i,
    output logic                     gnt_err_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DW-1:0]    mem_q [N][Depth];
    logic [DW-1:0]    mem_d [N][Depth];
    logic [PtrW-1:0]  wr_q [N], wr_d [N], rd_q [N], rd_d [N];
    logic [CntW-1:0]  cnt_q [N], cnt_d [N];
    logic [WaitW-1:0] wait_q [N], wait_d [N];
    logic [N-1:0]     stall_q, stall_d, push, pop, pend;
    logic             gnt_err_q, gnt_err_d;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        push    = '0;
        pop     = '0;
        pend    = '0;
        for (int i = 0; i < N; i++) begin
            ready_o[i] = cnt_q[i] != CntW'(Depth);
            req_o[i]   = cnt_q[i] != '0;
            data_o[i]  = req_o[i] ? mem_q[i][rd_q[i]] : '0;
            cnt_o[i]   = cnt_q[i];
            push[i]    = valid_i[i] && ready_o[i];
            pop[i]     = gnt_i[i] && req_o[i];
            pend[i]    = req_o[i] && !gnt_i[i];
            if (push[i]) begin
                mem_d[i][wr_q[i]] = data_i[i];
                wr_d[i]           = nxt(wr_q[i]);
            end
            if (pop[i]) rd_d[i] = nxt(rd_q[i]);
            cnt_d[i]   = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            wait_d[i]  = !pend[i] ? '0 :
                         (wait_q[i] == WaitW'(MaxWait)) ? wait_q[i] : wait_q[i] + 1'b1;
            // set takes priority over a same-cycle clear
            stall_d[i] = (pend[i] && wait_d[i] == WaitW'(MaxWait)) || (stall_q[i] && !stall_clr_i);
        end
        gnt_err_d = gnt_err_q || |(gnt_i & ~req_o) || ($countones(gnt_i) > 1);
        stall_o   = stall_q;
        gnt_err_o = gnt_err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                wr_q[i]   <= '0;
                rd_q[i]   <= '0;
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
            stall_q   <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            gnt_err_q <= gnt_err_d;
        end
    end
endmodule
